// File: rtl/multiplexer_n_inputs_buffered.sv
// N-input word selector with select-range flagging, presented through a
// registered valid/ready output stage backed by a one-entry skid buffer.
module multiplexer_n_inputs_buffered #(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned N_INPUTS = 4,
    localparam int unsigned SEL_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_sel_err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             accept;
    logic             emit;
    logic             head_load_in;
    logic             head_load_skid;
    logic             skid_load;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // Out-of-range selects resolve to zero data with the error flag set.
    always_comb begin
        sel_word = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < int'(N_INPUTS); k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    // Next-state and datapath steering.
    always_comb begin
        state_nxt      = state;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_ONE;
                    head_load_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    head_load_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    skid_load = 1'b1;
                end else if (emit) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_nxt      = ST_ONE;
                    head_load_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Head and skid registers; the head keeps its last word while empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data    <= '0;
            out_sel_err <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else begin
            if (head_load_in) begin
                out_data    <= sel_word;
                out_sel_err <= sel_err;
            end else if (head_load_skid) begin
                out_data    <= skid_data;
                out_sel_err <= skid_err;
            end
            if (skid_load) begin
                skid_data <= sel_word;
                skid_err  <= sel_err;
            end
        end
    end

endmodule
